rca_result_checker: RTL and testbench

Self-checking response monitor for the ripple-carry adder family. It sits on the adder's output side and samples each applied operand vector {cin, a, b} together with the DUT's {cout, s}. It compares them against a golden sum, counts vectors and mismatches, records the first failure, and tracks exhaustive coverage of the 2^(2·WIDTH+1) input space. When every distinct vector has been seen, it raises a pass/fail verdict.

---
 rtl/rca_result_checker.sv | 168 ++++++++++++++++
 tb/tb_rca_result_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rca_result_checker.sv
// -----------------------------------------------------------------------------
// rca_result_checker
//
// Response monitor for a WIDTH-bit ripple-carry adder. Each valid sample
// {cin, a, b} / {cout, s} is compared against a golden a + b + cin. The block
// counts samples and mismatches, latches the first failing vector and tracks
// coverage of all NVEC = 2^(2*WIDTH+1) input vectors. Once every vector has
// been seen it stops in DONE with a pass/fail verdict.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse: clear everything and (re)enter CHECK
//   vld              a/b/cin/s/cout hold a sample to check this cycle
//   a, b, cin        operands applied to the adder under test
//   s, cout          adder response
//   busy, done       high in CHECK / high in DONE
//   pass             done with zero mismatches
//   vec_count        accepted samples, duplicates included (saturating)
//   err_count        mismatching samples (saturating)
//   fail_seen        at least one mismatch since start
//   first_fail_vec   {cin, a, b} of the first mismatch
//   first_fail_got   {cout, s} of the first mismatch
//   dbg_state        current FSM state (0 IDLE, 1 CHECK, 2 DONE)
//
// Handshake: a sample is consumed on every rising edge where vld is high and
// the FSM is in CHECK and start is low. There is no ready/backpressure; vld
// may stay high every cycle. start has priority over vld in the same cycle.
// -----------------------------------------------------------------------------
module rca_result_checker #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 vld,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic [WIDTH-1:0]     s,
    input  logic                 cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   vec_count,
    output logic [2*WIDTH+1:0]   err_count,
    output logic                 fail_seen,
    output logic [2*WIDTH:0]     first_fail_vec,
    output logic [WIDTH:0]       first_fail_got,
    output logic [1:0]           dbg_state
);

    localparam int VW   = 2*WIDTH + 1;   // vector index width
    localparam int NVEC = 1 << VW;       // size of the input space
    localparam int CW   = 2*WIDTH + 2;   // counter width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [CW-1:0]     r_vec_count;
    logic [CW-1:0]     r_err_count;
    logic              r_fail_seen;
    logic [VW-1:0]     r_first_fail_vec;
    logic [WIDTH:0]    r_first_fail_got;
    logic [NVEC-1:0]   r_cov;

    logic [VW-1:0]     w_idx;
    logic [WIDTH:0]    w_exp;
    logic [WIDTH:0]    w_got;
    logic              w_mismatch;
    logic [NVEC-1:0]   w_onehot;
    logic [NVEC-1:0]   w_cov_next;
    logic              w_cov_full;
    logic [CW-1:0]     w_vec_next;
    logic [CW-1:0]     w_err_next;

    always_comb begin
        w_idx = {cin, a, b};
        w_exp = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        w_got = {cout, s};
        // Case inequality: an X/Z in the response counts as a mismatch in
        // simulation; synthesis treats it as a plain compare.
        w_mismatch = (w_got !== w_exp);

        w_onehot        = '0;
        w_onehot[w_idx] = 1'b1;
        w_cov_next      = r_cov | w_onehot;
        // Completion includes the bit set by the sample being accepted now.
        w_cov_full      = &w_cov_next;

        w_vec_next = (r_vec_count == {CW{1'b1}}) ? r_vec_count : r_vec_count + CW'(1);
        w_err_next = r_err_count;
        if (w_mismatch && (r_err_count != {CW{1'b1}})) begin
            w_err_next = r_err_count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_vec_count      <= '0;
            r_err_count      <= '0;
            r_fail_seen      <= 1'b0;
            r_first_fail_vec <= '0;
            r_first_fail_got <= '0;
            r_cov            <= '0;
        end else if (start) begin
            // Start from any state: clear the run, drop any coincident sample.
            r_state          <= ST_CHECK;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_vec_count      <= '0;
            r_err_count      <= '0;
            r_fail_seen      <= 1'b0;
            r_first_fail_vec <= '0;
            r_first_fail_got <= '0;
            r_cov            <= '0;
        end else begin
            case (r_state)
                ST_CHECK: begin
                    if (vld) begin
                        r_vec_count <= w_vec_next;
                        r_err_count <= w_err_next;
                        r_cov       <= w_cov_next;
                        if (w_mismatch && !r_fail_seen) begin
                            r_fail_seen      <= 1'b1;
                            r_first_fail_vec <= w_idx;
                            r_first_fail_got <= w_got;
                        end
                        if (w_cov_full) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end
                    end
                end
                ST_DONE: begin
                    // Verdict and counters held until the next start.
                end
                default: begin
                    // IDLE: samples ignored.
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign vec_count      = r_vec_count;
    assign err_count      = r_err_count;
    assign fail_seen      = r_fail_seen;
    assign first_fail_vec = r_first_fail_vec;
    assign first_fail_got = r_first_fail_got;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_rca_result_checker.sv
module tb_rca_result_checker;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             vld;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [9:0]       vec_count;
  logic [9:0]       err_count;
  logic             fail_seen;
  logic [8:0]       first_fail_vec;
  logic [4:0]       first_fail_got;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  rca_result_checker #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .vld            (vld),
    .a              (a),
    .b              (b),
    .cin            (cin),
    .s              (s),
    .cout           (cout),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .vec_count      (vec_count),
    .err_count      (err_count),
    .fail_seen      (fail_seen),
    .first_fail_vec (first_fail_vec),
    .first_fail_got (first_fail_got),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, the DUT samples on the
  // rising edge, outputs are checked on the following falling edge.
  task automatic drive_vec(input int vec, input bit fault);
    logic [4:0] sum;
    @(negedge clk);
    vld = 1'b1;
    {cin, a, b} = 9'(vec);
    sum = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (fault) sum[0] = 1'b0;     // s[0] stuck-at-0
    {cout, s} = sum;
  endtask

  task automatic go_idle();
    @(negedge clk);
    vld = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    vld = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; vld = 1'b0;
    a = '0; b = '0; cin = 1'b0; s = '0; cout = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, pass, fail_seen} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {busy, done, pass, fail_seen}); end
    checks++; if (vec_count !== 10'd0) begin errors++; $display("FAIL rst_vec_count got %0d exp 0", vec_count); end
    checks++; if (err_count !== 10'd0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", err_count); end
    checks++; if ({first_fail_vec, first_fail_got} !== 14'd0) begin errors++; $display("FAIL rst_first_fail got %h exp 0", {first_fail_vec, first_fail_got}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_exhaustive();
    pulse_start();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL exh_start busy/done got %b%b exp 10", busy, done); end
    for (int v = 0; v < 512; v++) drive_vec(v, 1'b0);
    go_idle();
    checks++; if ({busy, done, pass} !== 3'b011) begin errors++; $display("FAIL exh_flags got %b exp 011", {busy, done, pass}); end
    checks++; if (vec_count !== 10'd512) begin errors++; $display("FAIL exh_vec_count got %0d exp 512", vec_count); end
    checks++; if (err_count !== 10'd0 || fail_seen !== 1'b0) begin errors++; $display("FAIL exh_errors got %0d/%b exp 0/0", err_count, fail_seen); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL exh_state got %0d exp 2", dbg_state); end
  endtask

  task automatic test_fault();
    pulse_start();
    for (int v = 0; v < 512; v++) drive_vec(v, 1'b1);
    go_idle();
    checks++; if (err_count !== 10'd256) begin errors++; $display("FAIL flt_err_count got %0d exp 256", err_count); end
    checks++; if (first_fail_vec !== 9'h001) begin errors++; $display("FAIL flt_first_vec got %h exp 001", first_fail_vec); end
    checks++; if (first_fail_got !== 5'b00000) begin errors++; $display("FAIL flt_first_got got %b exp 00000", first_fail_got); end
    checks++; if ({done, pass, fail_seen} !== 3'b101) begin errors++; $display("FAIL flt_flags got %b exp 101", {done, pass, fail_seen}); end
    checks++; if (vec_count !== 10'd512) begin errors++; $display("FAIL flt_vec_count got %0d exp 512", vec_count); end
  endtask

  task automatic test_duplicates();
    pulse_start();
    repeat (3) drive_vec(0, 1'b0);
    for (int v = 1; v < 511; v++) drive_vec(v, 1'b0);
    go_idle();
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL dup_early_done got %b exp 10", {busy, done}); end
    checks++; if (vec_count !== 10'd513) begin errors++; $display("FAIL dup_mid_count got %0d exp 513", vec_count); end
    drive_vec(511, 1'b0);
    go_idle();
    checks++; if ({busy, done, pass} !== 3'b011) begin errors++; $display("FAIL dup_flags got %b exp 011", {busy, done, pass}); end
    checks++; if (vec_count !== 10'd514) begin errors++; $display("FAIL dup_vec_count got %0d exp 514", vec_count); end
    // DONE ignores further samples, even faulty ones
    drive_vec(1, 1'b1);
    drive_vec(3, 1'b1);
    go_idle();
    checks++; if (vec_count !== 10'd514 || err_count !== 10'd0) begin errors++; $display("FAIL done_hold got %0d/%0d exp 514/0", vec_count, err_count); end
  endtask

  task automatic test_incomplete();
    pulse_start();
    for (int v = 0; v < 511; v++) drive_vec(v, 1'b0);
    go_idle();
    checks++; if ({busy, done, pass} !== 3'b100) begin errors++; $display("FAIL inc_flags got %b exp 100", {busy, done, pass}); end
    checks++; if (vec_count !== 10'd511) begin errors++; $display("FAIL inc_vec_count got %0d exp 511", vec_count); end
    // idle cycles in CHECK do not change anything
    repeat (3) @(negedge clk);
    drive_vec(9'h1FF, 1'b0);
    go_idle();
    checks++; if ({busy, done, pass} !== 3'b011) begin errors++; $display("FAIL inc_final got %b exp 011", {busy, done, pass}); end
  endtask

  task automatic test_start_vld_same();
    // currently in DONE; start with a coincident faulty sample
    @(negedge clk);
    start = 1'b1; vld = 1'b1;
    {cin, a, b} = 9'h001; {cout, s} = 5'b00000;
    @(negedge clk);
    start = 1'b0; vld = 1'b0;
    checks++; if (vec_count !== 10'd0 || err_count !== 10'd0) begin errors++; $display("FAIL sv_counts got %0d/%0d exp 0/0", vec_count, err_count); end
    checks++; if ({busy, done, pass, fail_seen} !== 4'b1000) begin errors++; $display("FAIL sv_flags got %b exp 1000", {busy, done, pass, fail_seen}); end
    // first failure latched, later failure does not overwrite
    drive_vec(5, 1'b0);
    drive_vec(9'h003, 1'b1);   // 0+3 -> got 00010
    drive_vec(9'h101, 1'b1);   // 1+0+1=2, even, matches
    drive_vec(9'h007, 1'b1);   // 0+7 -> got 00110
    go_idle();
    checks++; if (err_count !== 10'd2 || vec_count !== 10'd4) begin errors++; $display("FAIL sv_run got %0d/%0d exp 2/4", err_count, vec_count); end
    checks++; if (first_fail_vec !== 9'h003 || first_fail_got !== 5'b00010) begin errors++; $display("FAIL sv_first got %h/%b exp 003/00010", first_fail_vec, first_fail_got); end
    // X on the response counts as a mismatch
    @(negedge clk);
    vld = 1'b1; {cin, a, b} = 9'h011; s = 4'bxxxx; cout = 1'b0;
    go_idle();
    checks++; if (err_count !== 10'd3) begin errors++; $display("FAIL x_mismatch got %0d exp 3", err_count); end
    // start in CHECK aborts the run
    pulse_start();
    checks++; if (err_count !== 10'd0 || fail_seen !== 1'b0 || first_fail_vec !== 9'd0 || busy !== 1'b1) begin errors++; $display("FAIL abort got %0d/%b/%h/%b exp 0/0/000/1", err_count, fail_seen, first_fail_vec, busy); end
  endtask

  task automatic test_saturate();
    pulse_start();
    for (int i = 0; i < 1030; i++) drive_vec(1, 1'b1);
    go_idle();
    checks++; if (vec_count !== 10'h3FF || err_count !== 10'h3FF) begin errors++; $display("FAIL saturate got %0d/%0d exp 1023/1023", vec_count, err_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat_busy got %b exp 1", busy); end
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    for (int v = 0; v < 100; v++) drive_vec(v, 1'b1);
    @(posedge clk);   // 100th sample taken here
    #1;
    checks++; if (vec_count !== 10'd100) begin errors++; $display("FAIL mid_before got %0d exp 100", vec_count); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, pass, fail_seen} !== 4'b0000 || vec_count !== 10'd0 || err_count !== 10'd0) begin errors++; $display("FAIL mid_async got %b/%0d/%0d exp 0000/0/0", {busy, done, pass, fail_seen}, vec_count, err_count); end
    checks++; if (first_fail_vec !== 9'd0 || first_fail_got !== 5'd0 || dbg_state !== 2'd0) begin errors++; $display("FAIL mid_first got %h/%b/%0d exp 0/0/0", first_fail_vec, first_fail_got, dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 200; v < 205; v++) drive_vec(v, 1'b1);
    go_idle();
    checks++; if (vec_count !== 10'd0 || dbg_state !== 2'd0) begin errors++; $display("FAIL idle_vld got %0d/%0d exp 0/0", vec_count, dbg_state); end
    // coverage bitmap was cleared by reset: a fresh run needs the full sweep
    pulse_start();
    for (int v = 100; v < 512; v++) drive_vec(v, 1'b0);
    go_idle();
    checks++; if (done !== 1'b0 || vec_count !== 10'd412) begin errors++; $display("FAIL cov_clear got %b/%0d exp 0/412", done, vec_count); end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_fault();
    test_duplicates();
    test_incomplete();
    test_start_vld_same();
    test_saturate();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
